wb_int_ctrl: RTL and testbench

Parametrised Wishbone-slave interrupt controller. It replaces the fixed OR/priority mux that produces CPU_INT/CPU_CAUSE at the top level. It takes NUM_SRC asynchronous interrupt sources and synchronises them. Each source has its own mask and edge/level mode; pending bits are clear-on-write; a registered INT and CAUSE drive the multi-cycle CPU.

---
 rtl/int_ctrl_pkg.sv | 20 ++
 rtl/int_prio_enc.sv | 32 +++
 rtl/wb_int_ctrl.sv | 155 +++++++++++++++
 tb/tb_wb_int_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared constants for the Wishbone interrupt controller: register offsets,
// source mode encodings and the idle cause code.
package int_ctrl_pkg;

    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_MASK    = 2'd1;
    localparam logic [1:0] REG_MODE    = 2'd2;
    localparam logic [1:0] REG_CAUSE   = 2'd3;

    localparam logic MODE_LEVEL = 1'b0;
    localparam logic MODE_EDGE  = 1'b1;

    localparam logic [31:0] CAUSE_NONE = 32'h0;

    // Width of a source index; one source still needs a 1-bit index port.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Combinational find-first-set over req, searching upward from start and
// wrapping back to index 0.
module int_prio_enc #(
    parameter int N  = 8,
    parameter int PW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] start,
    output logic          valid,
    output logic [PW-1:0] idx
);

    logic [PW:0] pos;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        pos   = '0;
        // Walk from the farthest offset so the hit nearest to start is assigned last.
        for (int off = N - 1; off >= 0; off--) begin
            pos = {1'b0, start} + (PW + 1)'(off);
            if (pos >= (PW + 1)'(N)) begin
                pos = pos - (PW + 1)'(N);
            end
            if (req[pos[PW-1:0]]) begin
                valid = 1'b1;
                idx   = pos[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/wb_int_ctrl.sv
// Wishbone interrupt controller: synchronised sources, per-source mask and
// edge/level mode, W1C pending bits, registered INT/CAUSE for the CPU.
// Define INT_CTRL_RR_EN to select the reported source round-robin instead of lowest index.
module wb_int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int          NUM_SRC    = 8,
    parameter logic [31:0] CAUSE_BASE = 32'h0,
    parameter logic [31:0] MASK_RST   = 32'h0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src,
    input  logic               STB,
    input  logic               WE,
    input  logic [31:0]        ADDR,
    input  logic [31:0]        DAT_I,
    output logic [31:0]        DAT_O,
    output logic               ACK,
    output logic               INT,
    output logic [31:0]        CAUSE
);

    localparam int PW = ptr_width(NUM_SRC);

    logic [NUM_SRC-1:0] sync1_q, sync1_d;
    logic [NUM_SRC-1:0] sync2_q, sync2_d;
    logic [NUM_SRC-1:0] prev_q, prev_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] mode_q, mode_d;
    logic               ack_q, ack_d;
    logic               int_q, int_d;
    logic [31:0]        cause_q, cause_d;
    logic [31:0]        dat_o_q, dat_o_d;

    logic [1:0]         reg_sel;
    logic               commit;
    logic               wr;
    logic [NUM_SRC-1:0] wdata;
    logic [NUM_SRC-1:0] w1c;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] act;
    logic               enc_valid;
    logic [PW-1:0]      enc_idx;
    logic [PW-1:0]      enc_start;
    logic               unused_bits;

    assign unused_bits = ^{ADDR[31:4], ADDR[1:0], DAT_I};

    always_comb begin
        reg_sel = ADDR[3:2];
        wdata   = DAT_I[NUM_SRC-1:0];
        // A transaction commits only on the first strobed cycle before ACK is up.
        commit  = STB & ~ack_q;
        wr      = commit & WE;
        w1c     = (wr && reg_sel == REG_PENDING) ? wdata : '0;

        sync1_d = src;
        sync2_d = sync1_q;
        prev_d  = sync2_q;

        // Edge sources latch rising edges (set beats W1C); level sources track sync.
        rise      = sync2_q & ~prev_q;
        pending_d = (mode_q & (rise | (pending_q & ~w1c))) | (~mode_q & sync2_q);

        mask_d = (wr && reg_sel == REG_MASK) ? wdata : mask_q;
        mode_d = (wr && reg_sel == REG_MODE) ? wdata : mode_q;

        act     = pending_q & mask_q;
        int_d   = enc_valid;
        cause_d = enc_valid ? CAUSE_BASE + 32'(enc_idx) : CAUSE_NONE;

        ack_d   = STB;
        dat_o_d = dat_o_q;
        if (commit) begin
            case (reg_sel)
                REG_PENDING: dat_o_d = 32'(pending_q);
                REG_MASK:    dat_o_d = 32'(mask_q);
                REG_MODE:    dat_o_d = 32'(mode_q);
                default:     dat_o_d = cause_q;
            endcase
        end
    end

    int_prio_enc #(
        .N  (NUM_SRC),
        .PW (PW)
    ) u_prio_enc (
        .req   (act),
        .start (enc_start),
        .valid (enc_valid),
        .idx   (enc_idx)
    );

`ifdef INT_CTRL_RR_EN
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] sel_idx_q, sel_idx_d;

    always_comb begin
        ptr_d     = ptr_q;
        sel_idx_d = enc_idx;
        // Clearing the reported edge source moves the search start just past it.
        if (int_q && w1c[sel_idx_q] && mode_q[sel_idx_q] == MODE_EDGE) begin
            ptr_d = (sel_idx_q == PW'(NUM_SRC - 1)) ? '0 : sel_idx_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            sel_idx_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            sel_idx_q <= sel_idx_d;
        end
    end

    assign enc_start = ptr_q;
`else
    assign enc_start = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            pending_q <= '0;
            mode_q    <= '0;
            mask_q    <= MASK_RST[NUM_SRC-1:0];
            ack_q     <= 1'b0;
            int_q     <= 1'b0;
            cause_q   <= CAUSE_NONE;
            dat_o_q   <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            pending_q <= pending_d;
            mode_q    <= mode_d;
            mask_q    <= mask_d;
            ack_q     <= ack_d;
            int_q     <= int_d;
            cause_q   <= cause_d;
            dat_o_q   <= dat_o_d;
        end
    end

    assign DAT_O = dat_o_q;
    assign ACK   = ack_q;
    assign INT   = int_q;
    assign CAUSE = cause_q;

endmodule

// File: tb/tb_wb_int_ctrl.sv
// Scoreboard bench for wb_int_ctrl: a reference model pushes expected INT/CAUSE/ACK
// and read data; a monitor pops and compares on every cycle and every ACK rise.
module tb_wb_int_ctrl;

    localparam int N = 8;
    localparam int unsigned NMASK = 32'hFF;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] src = '0;
    logic         STB = 1'b0;
    logic         WE = 1'b0;
    logic [31:0]  ADDR = '0;
    logic [31:0]  DAT_I = '0;
    logic [31:0]  DAT_O;
    logic         ACK;
    logic         INT;
    logic [31:0]  CAUSE;

    int n_tests = 0;
    int n_fail = 0;
    bit rnd_src = 1'b0;

    wb_int_ctrl #(
        .NUM_SRC    (N),
        .CAUSE_BASE (32'h0),
        .MASK_RST   (32'h0)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .src   (src),
        .STB   (STB),
        .WE    (WE),
        .ADDR  (ADDR),
        .DAT_I (DAT_I),
        .DAT_O (DAT_O),
        .ACK   (ACK),
        .INT   (INT),
        .CAUSE (CAUSE)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          i;
        logic [31:0] c;
        bit          a;
    } exp_t;

    exp_t        ic_q[$];
    logic [31:0] rd_q[$];

    // Reference model state: registers as plain integers plus a sample history of src.
    int unsigned m_p = 0, m_mask = 0, m_mode = 0, m_cause = 0;
    bit          m_int = 0, m_ack = 0;
    int          m_ptr = 0, m_sel = 0;
    int unsigned hist[$] = '{0, 0, 0};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_step();
        int unsigned sync, prv, act, w1c, np;
        int          win, sel, j;
        bit          commit, wr;
        if (rst) begin
            m_p = 0; m_mask = 0; m_mode = 0; m_cause = 0;
            m_int = 0; m_ack = 0; m_ptr = 0; m_sel = 0;
            hist = '{0, 0, 0};
            ic_q.push_back('{1'b0, 32'h0, 1'b0});
            return;
        end
        // Value seen by the pending logic now was sampled two edges ago; prev three.
        sync = hist[1];
        prv  = hist[2];
        act  = m_p & m_mask;
        win  = -1;
        for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (win < 0 && act[j]) win = j;
        end
        sel    = int'(ADDR[3:2]);
        commit = STB && !m_ack;
        wr     = commit && WE;
        w1c    = (wr && sel == 0) ? (DAT_I & NMASK) : 0;
        if (commit) begin
            case (sel)
                0: rd_q.push_back(m_p);
                1: rd_q.push_back(m_mask);
                2: rd_q.push_back(m_mode);
                default: rd_q.push_back(m_cause);
            endcase
        end
`ifdef INT_CTRL_RR_EN
        if (m_int && w1c[m_sel] && m_mode[m_sel]) m_ptr = (m_sel + 1) % N;
`endif
        np = 0;
        for (int b = 0; b < N; b++) begin
            if (m_mode[b]) begin
                if (sync[b] && !prv[b]) np[b] = 1'b1;
                else if (m_p[b] && !w1c[b]) np[b] = 1'b1;
            end else begin
                np[b] = sync[b];
            end
        end
        m_p = np;
        if (wr && sel == 1) m_mask = DAT_I & NMASK;
        if (wr && sel == 2) m_mode = DAT_I & NMASK;
        m_int   = (win >= 0);
        m_cause = (win >= 0) ? 32'(win) : 32'h0;
        if (win >= 0) m_sel = win;
        m_ack = STB;
        hist.push_front(32'(src));
        void'(hist.pop_back());
        ic_q.push_back('{m_int, m_cause, m_ack});
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Monitor: decoupled from stimulus, consumes whatever the model has queued.
    initial begin
        exp_t e;
        logic [31:0] w;
        bit ack_prev;
        ack_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (ic_q.size() > 0) begin
                e = ic_q.pop_front();
                chk("INT", 32'(INT), 32'(e.i));
                chk("CAUSE", CAUSE, e.c);
                chk("ACK", 32'(ACK), 32'(e.a));
            end
            if (ACK === 1'b1 && !ack_prev) begin
                if (rd_q.size() == 0) begin
                    chk("DAT_O_unexpected_ack", 32'(ACK), 32'h0);
                end else begin
                    w = rd_q.pop_front();
                    chk("DAT_O", DAT_O, w);
                end
            end
            ack_prev = (ACK === 1'b1);
        end
    end

    task automatic cyc();
        @(negedge clk);
        if (rnd_src && ($urandom % 4) == 0) src = N'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    // One Wishbone access; upper/lower ADDR bits are randomised to exercise aliasing.
    task automatic bus(input bit we, input int a, input logic [31:0] d, input int hold);
        logic [31:0] r;
        r     = $urandom;
        STB   = 1'b1;
        WE    = we;
        ADDR  = {r[31:4], a[1:0], r[1:0]};
        DAT_I = d;
        cyc();
        repeat (hold) begin
            WE    = 1'($urandom);
            DAT_I = $urandom;
            cyc();
        end
        STB   = 1'b0;
        WE    = 1'($urandom);
        ADDR  = $urandom;
        DAT_I = $urandom;
        cyc();
    endtask

    task automatic pulse(input int b);
        src[b] = 1'b1;
        cyc();
        src[b] = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Reset state readback of all four offsets.
        for (int a = 0; a < 4; a++) bus(1'b0, a, 32'h0, a % 2);

        // Edge mode, masked-in source 3 pulse, then clear.
        bus(1'b1, 2, 32'hFF, 0);
        bus(1'b1, 1, 32'h0A, 0);
        pulse(3);
        idle(6);
        bus(1'b0, 0, 32'h0, 0);
        bus(1'b1, 0, 32'h08, 1);
        idle(3);

        // Two simultaneous edges; lowest wins, then the next after W1C.
        src[1] = 1'b1; src[3] = 1'b1;
        cyc();
        src[1] = 1'b0; src[3] = 1'b0;
        idle(5);
        bus(1'b1, 0, 32'h02, 0);
        idle(2);
        pulse(1);
        idle(5);
        bus(1'b1, 0, 32'h08, 0);
        idle(3);
        bus(1'b1, 0, 32'hFF, 0);

        // Level mode: W1C has no effect while the source is held.
        bus(1'b1, 2, 32'h00, 0);
        bus(1'b1, 1, 32'h20, 0);
        src[5] = 1'b1;
        idle(5);
        bus(1'b1, 0, 32'h20, 0);
        bus(1'b0, 0, 32'h0, 0);
        src[5] = 1'b0;
        idle(5);

        // Masked source records pending; unmasking raises INT.
        bus(1'b1, 2, 32'hFF, 0);
        bus(1'b1, 1, 32'h00, 0);
        pulse(0);
        idle(5);
        bus(1'b0, 0, 32'h0, 0);
        bus(1'b1, 1, 32'h01, 0);
        idle(3);

        // W1C colliding with a new edge on the same bit: set wins.
        pulse(2);
        idle(5);
        pulse(2);
        cyc();
        bus(1'b1, 0, 32'h04, 0);
        bus(1'b0, 0, 32'h0, 0);

        // Reset asserted on the would-be commit edge of a MASK write.
        STB = 1'b1; WE = 1'b1; ADDR = 32'h4; DAT_I = 32'h55; rst = 1'b1;
        cyc();
        rst = 1'b0; STB = 1'b0;
        cyc();
        bus(1'b0, 1, 32'h0, 0);
        bus(1'b0, 0, 32'h0, 0);

        // Randomised traffic with free-running sources.
        rnd_src = 1'b1;
        for (int it = 0; it < 300; it++) begin
            case ($urandom % 6)
                0: idle(1 + $urandom % 4);
                1: bus(1'b0, int'($urandom % 4), 32'h0, int'($urandom % 3));
                2: bus(1'b1, 0, $urandom, int'($urandom % 3));
                3: bus(1'b1, int'($urandom % 4), $urandom, int'($urandom % 3));
                4: begin
                    if (($urandom % 20) == 0) begin
                        rst = 1'b1;
                        cyc();
                        rst = 1'b0;
                    end else begin
                        idle(2);
                    end
                end
                default: bus(1'b0, 3, 32'h0, 0);
            endcase
        end
        rnd_src = 1'b0;
        src = '0;
        idle(8);
        chk("rd_queue_drained", 32'(rd_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
